diff_monitor: RTL
=================

Name: diff_monitor

Overview:
- Sits directly downstream of the 4-bit difference stage (XOR-per-bit, OR-reduced "operands differ" flag).
- Samples that 1-bit flag under a valid qualifier and keeps saturating statistics: total samples, total mismatches, current consecutive-mismatch run.
- Raises a sticky alarm once the run reaches a programmable limit.
- Feeds the ALU test/status logic with registered, cycle-accurate status.

Parameters:
CNT_W, 8, width of all counters; legal range 2..16.
RUN_LIMIT, 3, consecutive mismatches that trigger the alarm; legal range 1..(2^CNT_W - 1).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  diff is a valid sample this cycle.
diff  input  1  difference-stage output: 1 = operands differ, 0 = equal.
clear  input  1  synchronous clear of all state; priority over in_valid.
sample_count  output  CNT_W  accepted samples, saturating.
mismatch_count  output  CNT_W  accepted samples with diff=1, saturating.
run_len  output  CNT_W  current consecutive mismatch run, saturating.
state  output  2  FSM state: 00 IDLE, 01 MATCH, 10 MISM, 11 ALARM.
alarm  output  1  1 iff state==ALARM.
out_valid  output  1  one-cycle pulse, the cycle after an accepted sample.

Behaviour:
- Reset (async, active-high): all counters 0, state IDLE, alarm 0, out_valid 0. Takes effect immediately and overrides any in-flight sample.
- All other updates happen on the rising edge of clk. All outputs are registered.
- Accepted sample: in_valid=1 and clear=0 at the clock edge. Latency is 1 cycle; counters, state and out_valid reflect the sample after that edge.
- clear=1: same values as reset on the next edge, including out_valid=0. A sample presented in the same cycle is dropped and not counted.
- in_valid=0 and clear=0: all state holds, out_valid=0. The diff value is ignored.
- On each accepted sample:
  - sample_count += 1.
  - If diff=1: mismatch_count += 1 and run_len += 1.
  - If diff=0: run_len is set to 0.
- Saturation: every counter stops at 2^CNT_W-1 and never wraps.
- FSM transitions, on accepted samples only:
  - From IDLE, MATCH or MISM with diff=0: go to MATCH.
  - From IDLE, MATCH or MISM with diff=1: go to ALARM if the new run_len >= RUN_LIMIT, otherwise go to MISM.
  - ALARM is sticky. Any sample leaves it in ALARM; counters and run_len keep updating (run_len still resets on diff=0).
  - ALARM exits only via clear or reset.
- RUN_LIMIT=1: the first mismatch goes straight to ALARM.
- Alarm detection uses the pre-saturation comparison new_run >= RUN_LIMIT. Because RUN_LIMIT <= 2^CNT_W-1, saturation never masks the alarm.
- Comparison and increment use CNT_W-bit unsigned arithmetic, with an internal carry used for saturation detection.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then 5 cycles with in_valid=0 -> all counters 0, state=00, alarm=0, out_valid never 1.
- Match/mismatch mix (RUN_LIMIT=3): samples diff=0,1,1,0,1 -> after the last one, sample_count=5, mismatch_count=3, run_len=1, state=10, alarm=0. out_valid pulses 5 times, each 1 cycle after its sample.
- Alarm and stickiness (RUN_LIMIT=3): diff=1,1,1 -> state=11, alarm=1, run_len=3. Then diff=0 -> run_len=0, state stays 11. Then clear=1 for 1 cycle -> everything 0, state=00.
- Clear vs valid collision: clear=1 together with in_valid=1, diff=1 -> sample_count=0, mismatch_count=0, out_valid=0 on the next cycle.
- Saturation (CNT_W=2, RUN_LIMIT=3): 6 consecutive diff=1 samples -> sample_count=3, mismatch_count=3, run_len=3, alarm asserted after the 3rd sample.
- Async reset mid-run: assert reset between clock edges while state=10 and run_len=2 -> outputs go to 0 before the next rising edge. After deassertion, diff=1 gives run_len=1 and state=10.

Source files
------------

// File: rtl/diff_monitor.sv
// Statistics and alarm monitor for the 1-bit "operands differ" flag.
// Counts samples, mismatches and the current mismatch run; raises a sticky alarm at RUN_LIMIT.
module diff_monitor #(
  parameter int CNT_W     = 8,
  parameter int RUN_LIMIT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             diff,
  input  logic             clear,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [CNT_W-1:0] run_len,
  output logic [1:0]       state,
  output logic             alarm,
  output logic             out_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    MATCH = 2'b01,
    MISM  = 2'b10,
    ALARM = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W:0]   LIMIT_W  = (CNT_W+1)'(RUN_LIMIT);

  // Saturating increment: the carry out of the widened sum marks overflow.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W:0] sum;
    sum = {1'b0, v} + {{CNT_W{1'b0}}, 1'b1};
    if (sum[CNT_W]) begin
      return CNT_MAX;
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] sample_r, sample_nxt_s;
  logic [CNT_W-1:0] mismatch_r, mismatch_nxt_s;
  logic [CNT_W-1:0] run_r, run_nxt_s;
  logic             alarm_r, out_valid_r, out_valid_nxt_s;
  logic [CNT_W:0]   run_wide_s;

  // Pre-saturation run length, so a saturated counter still trips the alarm.
  always_comb begin
    run_wide_s = {1'b0, run_r} + {{CNT_W{1'b0}}, 1'b1};
  end

  // Next-state and next-counter logic; clear wins over an in-flight sample.
  always_comb begin
    state_nxt_s     = state_r;
    sample_nxt_s    = sample_r;
    mismatch_nxt_s  = mismatch_r;
    run_nxt_s       = run_r;
    out_valid_nxt_s = 1'b0;
    if (clear) begin
      state_nxt_s    = IDLE;
      sample_nxt_s   = CNT_ZERO;
      mismatch_nxt_s = CNT_ZERO;
      run_nxt_s      = CNT_ZERO;
    end else if (in_valid) begin
      out_valid_nxt_s = 1'b1;
      sample_nxt_s    = sat_inc(sample_r);
      if (diff) begin
        mismatch_nxt_s = sat_inc(mismatch_r);
        run_nxt_s      = sat_inc(run_r);
      end else begin
        run_nxt_s = CNT_ZERO;
      end
      case (state_r)
        ALARM: state_nxt_s = ALARM;
        IDLE, MATCH, MISM: begin
          if (!diff) begin
            state_nxt_s = MATCH;
          end else if (run_wide_s >= LIMIT_W) begin
            state_nxt_s = ALARM;
          end else begin
            state_nxt_s = MISM;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end else begin
      out_valid_nxt_s = 1'b0;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      sample_r    <= CNT_ZERO;
      mismatch_r  <= CNT_ZERO;
      run_r       <= CNT_ZERO;
      alarm_r     <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      sample_r    <= sample_nxt_s;
      mismatch_r  <= mismatch_nxt_s;
      run_r       <= run_nxt_s;
      alarm_r     <= (state_nxt_s == ALARM);
      out_valid_r <= out_valid_nxt_s;
    end
  end

  assign sample_count   = sample_r;
  assign mismatch_count = mismatch_r;
  assign run_len        = run_r;
  assign state          = state_r;
  assign alarm          = alarm_r;
  assign out_valid      = out_valid_r;

endmodule
